feature_frame_assembler: RTL and testbench

Collects per-channel feature samples arriving one per beat from the sensor front end and assembles them into a complete `features_top` frame for `hdc_sensor_fusion`. Two frame buffers are used in ping-pong fashion, so the next frame can be collected while the fusion core holds the current one. The output side drives the fusion core's `fin_valid`/`fin_ready` handshake directly.

---
 rtl/hdc_frame_pkg.sv | 16 +
 rtl/feature_frame_bank.sv | 68 ++++++
 rtl/feature_frame_assembler.sv | 128 ++++++++++++
 tb/tb_feature_frame_assembler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hdc_frame_pkg.sv
// Shared types and constants for the HDC sensor-fusion frame path.
// Provides the frame-buffer state enum, default channel geometry and the
// width of the discarded-frame counter.
package hdc_frame_pkg;

    localparam int unsigned TOTAL_NUM_CHANNEL  = 214;
    localparam int unsigned FEAT_CHANNEL_WIDTH = 8;
    localparam int unsigned ERR_COUNT_W        = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } buf_state_t;

endpackage : hdc_frame_pkg

// File: rtl/feature_frame_bank.sv
// One frame buffer: slot storage with per-slot write enable plus its
// EMPTY/FILLING/FULL state register.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   wr_en         - store wr_data into slot wr_idx
//   wr_idx        - slot index for the write
//   wr_data       - sample value
//   wr_last       - this write completes the frame (buffer becomes FULL)
//   rd_done       - frame consumed, buffer returns to EMPTY
//   abort         - drop a partially filled frame (FILLING -> EMPTY)
//   state         - current buffer state
//   frame         - flattened slot contents, slot k at [k*CHANNEL_WIDTH +: CHANNEL_WIDTH]
module feature_frame_bank
    import hdc_frame_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = TOTAL_NUM_CHANNEL,
    parameter int unsigned CHANNEL_WIDTH = FEAT_CHANNEL_WIDTH,
    parameter int unsigned CHAN_IDX_W    = $clog2(NUM_CHANNELS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [CHAN_IDX_W-1:0]               wr_idx,
    input  logic [CHANNEL_WIDTH-1:0]            wr_data,
    input  logic                                wr_last,
    input  logic                                rd_done,
    input  logic                                abort,
    output buf_state_t                          state,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] frame
);

    buf_state_t state_nxt;

    // Buffer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: consume and write never target the same buffer in one cycle
    always_comb begin
        state_nxt = state;
        if (rd_done) begin
            state_nxt = EMPTY;
        end else if (abort && (state == FILLING)) begin
            state_nxt = EMPTY;
        end else if (wr_en) begin
            state_nxt = wr_last ? FULL : FILLING;
        end
    end

    // Slot storage; contents persist until overwritten by a later frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
                if (wr_en && (wr_idx == CHAN_IDX_W'(k))) begin
                    frame[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= wr_data;
                end
            end
        end
    end

endmodule : feature_frame_bank

// File: rtl/feature_frame_assembler.sv
// Assembles per-channel samples into full frames for hdc_sensor_fusion using
// two ping-pong frame buffers, so one frame is collected while the other is
// held for the fusion core.
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   s_valid/s_ready        - sample handshake
//   s_data, s_chan, s_last - sample value, channel index, end-of-frame marker
//   features_top           - frame presented to the fusion core
//   fin_valid/fin_ready    - frame handshake with the fusion core
//   frame_err              - one-cycle pulse when a frame is discarded
//   err_count              - saturating count of discarded frames
// Build option: define FRAME_SEQ_CHECK_EN to check s_chan/s_last on every
// accepted beat and discard malformed frames; otherwise those inputs are
// ignored and frame_err/err_count are tied low.
module feature_frame_assembler
    import hdc_frame_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS  = TOTAL_NUM_CHANNEL,
    parameter int unsigned CHANNEL_WIDTH = FEAT_CHANNEL_WIDTH,
    parameter int unsigned CHAN_IDX_W    = $clog2(NUM_CHANNELS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [CHANNEL_WIDTH-1:0]              s_data,
    input  logic [CHAN_IDX_W-1:0]                 s_chan,
    input  logic                                  s_last,
    output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] features_top,
    output logic                                  fin_valid,
    input  logic                                  fin_ready,
    output logic                                  frame_err,
    output logic [ERR_COUNT_W-1:0]                err_count
);

    localparam int unsigned FRAME_W = NUM_CHANNELS * CHANNEL_WIDTH;

    logic [CHAN_IDX_W-1:0] chan_cnt;
    logic                  wr_sel;
    logic                  rd_sel;

    buf_state_t            bank_state [2];
    logic [FRAME_W-1:0]    bank_frame [2];

    logic accept;
    logic last_beat;
    logic seq_err;
    logic wr_fire;
    logic complete;
    logic consume;

    assign s_ready      = (bank_state[wr_sel] != FULL);
    assign fin_valid    = (bank_state[rd_sel] == FULL);
    assign features_top = bank_frame[rd_sel];

    assign accept    = s_valid && s_ready;
    assign last_beat = (chan_cnt == CHAN_IDX_W'(NUM_CHANNELS - 1));
    assign wr_fire   = accept && !seq_err;
    assign complete  = wr_fire && last_beat;
    assign consume   = fin_valid && fin_ready;

    // Ping-pong frame buffers
    for (genvar b = 0; b < 2; b++) begin : g_bank
        feature_frame_bank #(
            .NUM_CHANNELS  (NUM_CHANNELS),
            .CHANNEL_WIDTH (CHANNEL_WIDTH),
            .CHAN_IDX_W    (CHAN_IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire && (wr_sel == 1'(b))),
            .wr_idx  (chan_cnt),
            .wr_data (s_data),
            .wr_last (last_beat),
            .rd_done (consume && (rd_sel == 1'(b))),
            .abort   (seq_err),
            .state   (bank_state[b]),
            .frame   (bank_frame[b])
        );
    end

    // Write slot counter and buffer pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_cnt <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
        end else begin
            if (seq_err || complete) begin
                chan_cnt <= '0;
            end else if (wr_fire) begin
                chan_cnt <= chan_cnt + CHAN_IDX_W'(1);
            end
            if (complete) begin
                wr_sel <= ~wr_sel;
            end
            if (consume) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

`ifdef FRAME_SEQ_CHECK_EN
    // Beat must carry the expected channel and a correctly placed last flag
    assign seq_err = accept && ((s_chan != chan_cnt) || (s_last != last_beat));

    // Discard reporting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            err_count <= '0;
        end else begin
            frame_err <= seq_err;
            if (seq_err && (err_count != '1)) begin
                err_count <= err_count + ERR_COUNT_W'(1);
            end
        end
    end
`else
    logic unused_seq;

    assign seq_err    = 1'b0;
    assign frame_err  = 1'b0;
    assign err_count  = '0;
    assign unused_seq = ^{s_chan, s_last};
`endif

endmodule : feature_frame_assembler

// File: tb/tb_feature_frame_assembler.sv
// Directed bench for feature_frame_assembler with 4 channels of 2 bits.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_feature_frame_assembler;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 2;
    localparam int unsigned IW  = 2;

    logic                clk;
    logic                rst;
    logic                s_valid;
    logic                s_ready;
    logic [CW-1:0]       s_data;
    logic [IW-1:0]       s_chan;
    logic                s_last;
    logic [NCH*CW-1:0]   features_top;
    logic                fin_valid;
    logic                fin_ready;
    logic                frame_err;
    logic [7:0]          err_count;

    int n_checks;
    int n_fail;

    feature_frame_assembler #(
        .NUM_CHANNELS  (NCH),
        .CHANNEL_WIDTH (CW),
        .CHAN_IDX_W    (IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_chan       (s_chan),
        .s_last       (s_last),
        .features_top (features_top),
        .fin_valid    (fin_valid),
        .fin_ready    (fin_ready),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded)
    task automatic send(input logic [CW-1:0] d, input logic [IW-1:0] ch, input logic last);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_chan  = ch;
        s_last  = last;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_chan    = '0;
        s_last    = 1'b0;
        fin_ready = 1'b0;
        tick();
        tick();
        check("rst_s_ready",   32'(s_ready),      32'd1);
        check("rst_fin_valid", 32'(fin_valid),    32'd0);
        check("rst_features",  32'(features_top), 32'd0);
        check("rst_frame_err", 32'(frame_err),    32'd0);
        check("rst_err_count", 32'(err_count),    32'd0);
        rst = 1'b1;
        tick();

        // 1: single frame, consumer always ready
        fin_ready = 1'b1;
        send(2'd3, 2'd0, 1'b0);
        check("s1_no_early_valid", 32'(fin_valid), 32'd0);
        send(2'd2, 2'd1, 1'b0);
        send(2'd1, 2'd2, 1'b0);
        send(2'd0, 2'd3, 1'b1);
        check("s1_fin_valid",  32'(fin_valid),    32'd1);
        check("s1_features",   32'(features_top), 32'h1B);
        tick();
        check("s1_valid_drop", 32'(fin_valid),    32'd0);
        fin_ready = 1'b0;

        // 2: three frames back-to-back, consumer stalled
        send(2'd1, 2'd0, 1'b0); send(2'd2, 2'd1, 1'b0);
        send(2'd3, 2'd2, 1'b0); send(2'd0, 2'd3, 1'b1);
        check("s2_ready_after_f1", 32'(s_ready), 32'd1);
        send(2'd2, 2'd0, 1'b0); send(2'd2, 2'd1, 1'b0);
        send(2'd1, 2'd2, 1'b0); send(2'd1, 2'd3, 1'b1);
        check("s2_ready_low",  32'(s_ready),      32'd0);
        check("s2_valid_a",    32'(fin_valid),    32'd1);
        check("s2_features_a", 32'(features_top), 32'h39);
        s_valid = 1'b1; s_data = 2'd3; s_chan = 2'd0; s_last = 1'b0;
        tick();
        tick();
        check("s2_held_ready", 32'(s_ready),      32'd0);
        check("s2_held_data",  32'(features_top), 32'h39);
        fin_ready = 1'b1;
        tick();
        fin_ready = 1'b0;
        check("s2_ready_rise", 32'(s_ready),      32'd1);
        check("s2_valid_b",    32'(fin_valid),    32'd1);
        check("s2_features_b", 32'(features_top), 32'h5A);
        tick();
        s_valid = 1'b0;
        send(2'd0, 2'd1, 1'b0); send(2'd3, 2'd2, 1'b0); send(2'd0, 2'd3, 1'b1);
        check("s2_features_b_hold", 32'(features_top), 32'h5A);
        fin_ready = 1'b1;
        tick();
        check("s2_valid_c",    32'(fin_valid),    32'd1);
        check("s2_features_c", 32'(features_top), 32'h33);
        tick();
        check("s2_drained",    32'(fin_valid),    32'd0);
        fin_ready = 1'b0;

        // 3: completion and consumption in the same cycle
        send(2'd0, 2'd0, 1'b0); send(2'd1, 2'd1, 1'b0);
        send(2'd2, 2'd2, 1'b0); send(2'd3, 2'd3, 1'b1);
        send(2'd1, 2'd0, 1'b0); send(2'd1, 2'd1, 1'b0); send(2'd1, 2'd2, 1'b0);
        check("s3_features_d", 32'(features_top), 32'hE4);
        fin_ready = 1'b1;
        send(2'd2, 2'd3, 1'b1);
        check("s3_valid_cont", 32'(fin_valid),    32'd1);
        check("s3_features_e", 32'(features_top), 32'h95);
        check("s3_ready",      32'(s_ready),      32'd1);
        tick();
        check("s3_drained",    32'(fin_valid),    32'd0);
        fin_ready = 1'b0;

`ifdef FRAME_SEQ_CHECK_EN
        // 4: channel skip discards the partial frame
        send(2'd1, 2'd0, 1'b0);
        send(2'd2, 2'd2, 1'b0);
        check("s4_frame_err",  32'(frame_err), 32'd1);
        check("s4_err_count",  32'(err_count), 32'd1);
        check("s4_no_valid",   32'(fin_valid), 32'd0);
        tick();
        check("s4_err_pulse",  32'(frame_err), 32'd0);
        send(2'd3, 2'd0, 1'b0); send(2'd1, 2'd1, 1'b0);
        send(2'd0, 2'd2, 1'b0); send(2'd2, 2'd3, 1'b1);
        check("s4_valid",      32'(fin_valid),    32'd1);
        check("s4_features",   32'(features_top), 32'h87);
        check("s4_err_count_hold", 32'(err_count), 32'd1);
`else
        // 6: channel index ignored, slots filled in arrival order
        send(2'd1, 2'd0, 1'b0);
        send(2'd2, 2'd2, 1'b0);
        check("s6_frame_err",  32'(frame_err), 32'd0);
        send(2'd3, 2'd0, 1'b0);
        send(2'd1, 2'd1, 1'b0);
        check("s6_valid",      32'(fin_valid),    32'd1);
        check("s6_features",   32'(features_top), 32'h79);
        check("s6_err_count",  32'(err_count),    32'd0);
`endif
        fin_ready = 1'b1;
        tick();
        check("s46_consumed", 32'(fin_valid), 32'd0);
        fin_ready = 1'b0;

        // 5: reset drops a waiting frame and a partial frame
        send(2'd1, 2'd0, 1'b0); send(2'd1, 2'd1, 1'b0);
        send(2'd1, 2'd2, 1'b0); send(2'd1, 2'd3, 1'b1);
        send(2'd3, 2'd0, 1'b0); send(2'd3, 2'd1, 1'b0);
        check("s5_pre_valid",    32'(fin_valid),    32'd1);
        check("s5_pre_features", 32'(features_top), 32'h55);
        rst = 1'b0;
        #1;
        check("s5_rst_valid",    32'(fin_valid),    32'd0);
        check("s5_rst_ready",    32'(s_ready),      32'd1);
        check("s5_rst_features", 32'(features_top), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send(2'd2, 2'd0, 1'b0); send(2'd3, 2'd1, 1'b0);
        send(2'd0, 2'd2, 1'b0); send(2'd1, 2'd3, 1'b1);
        check("s5_valid",    32'(fin_valid),    32'd1);
        check("s5_features", 32'(features_top), 32'h4E);
        fin_ready = 1'b1;
        tick();
        check("s5_alone", 32'(fin_valid), 32'd0);
        fin_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_feature_frame_assembler
